// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle ARM-subset datapath.
//   state_e      - FSM phase encoding, also visible on mc_datapath.phase
//   ALU_*        - alu_control encodings
//   IMM_*        - imm_src encodings
//   PC_REG       - register index that aliases the program counter
//   needs_mem()  - true when the instruction has a MEM phase
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_ZX8  = 2'b00;
    localparam logic [1:0] IMM_ZX12 = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;
    localparam logic [1:0] IMM_NONE = 2'b11;

    localparam logic [3:0] PC_REG = 4'd15;

    function automatic logic needs_mem(input logic mem_to_reg, input logic mem_write);
        return mem_to_reg | mem_write;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: R0..R14 architectural registers for mc_datapath.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (all registers -> 0)
//   ra1_i, ra2_i    - asynchronous read addresses; index 15 returns r15_i
//   r15_i           - value presented for reads of R15 (PC + 8 view)
//   we_i,wa_i,wd_i  - write port; writes addressed to R15 are dropped here,
//                     the PC itself lives in the datapath
//   rd1_o, rd2_o    - read data
module mc_regfile
    import mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ra1_i,
    input  logic [3:0]       ra2_i,
    input  logic [WIDTH-1:0] r15_i,
    input  logic             we_i,
    input  logic [3:0]       wa_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o
);

    logic [WIDTH-1:0] regs_q [0:14];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != PC_REG)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == PC_REG) ? r15_i : regs_q[ra1_i];
    assign rd2_o = (ra2_i == PC_REG) ? r15_i : regs_q[ra2_i];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle ARM-subset datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> WB over a single shared memory port
// with a valid/ready handshake; an external controller decodes `instr` and
// holds the control inputs stable from DECODE through WB.
//
// Parameters: WIDTH (32 or 64), RESET_PC (word-aligned PC after reset).
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   reg_src, reg_write, imm_src,
//   alu_src, alu_control,
//   mem_to_reg, mem_write, pc_src - controller-driven control set
//   instr      - latched instruction word
//   alu_flags  - NZCV from the most recent EXEC
//   phase      - current FSM state (mc_pkg::state_e)
//   retire     - one-cycle pulse in the cycle after WB
//   mem_req/mem_we/mem_addr/mem_wdata - registered memory request, held
//                until the edge where mem_req & mem_ready
//   mem_rdata, mem_ready          - memory response
//   instret    - retired-instruction count
//
// Optional feature: define MC_DATAPATH_INSTRET_EN to build the 32-bit
// instret counter; otherwise instret is tied to zero.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       reg_src,
    input  logic             reg_write,
    input  logic [1:0]       imm_src,
    input  logic             alu_src,
    input  logic [1:0]       alu_control,
    input  logic             mem_to_reg,
    input  logic             mem_write,
    input  logic             pc_src,
    output logic [31:0]      instr,
    output logic [3:0]       alu_flags,
    output logic [2:0]       phase,
    output logic             retire,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      instret
);

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [31:0]      instr_q;
    logic [3:0]       flags_q;
    logic             retire_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] aluout_q;
    logic [WIDTH-1:0] data_q;

    logic [3:0]       ra1;
    logic [3:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flg;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] pc_next_d;
    logic             rf_we;

    function automatic logic [WIDTH-1:0] ext_imm(input logic [1:0] src, input logic [23:0] f);
        logic [WIDTH-1:0] v;
        v = '0;
        case (src)
            IMM_ZX8:  v = WIDTH'(f[7:0]);
            IMM_ZX12: v = WIDTH'(f[11:0]);
            // Branch offset: word offset scaled to bytes, then sign-extended.
            IMM_BR:   v = {{(WIDTH-26){f[23]}}, f, 2'b00};
            IMM_NONE: v = '0;
            default:  v = '0;
        endcase
        return v;
    endfunction

    // Returns {N, Z, C, V, result}. Subtract is A + ~B + 1 so C means "no borrow".
    function automatic logic [WIDTH+3:0] alu_f(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        sum = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            ALU_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: r = a & b;
            ALU_ORR: r = a | b;
            default: r = '0;
        endcase
        return {r[WIDTH-1], (r == '0), c, v, r};
    endfunction

    assign ra1 = reg_src[0] ? PC_REG : instr_q[19:16];
    assign ra2 = reg_src[1] ? instr_q[15:12] : instr_q[3:0];

    // pc_q already points at the next instruction during DECODE, so the
    // architectural R15 (instruction address + 8) is pc_q + 4.
    mc_regfile #(.WIDTH(WIDTH)) u_rf (
        .clk   (clk),
        .reset (reset),
        .ra1_i (ra1),
        .ra2_i (ra2),
        .r15_i (pc_q + WIDTH'(4)),
        .we_i  (rf_we),
        .wa_i  (instr_q[15:12]),
        .wd_i  (result),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    assign src_b              = alu_src ? imm_q : b_q;
    assign {alu_flg, alu_res} = alu_f(alu_control, a_q, src_b);
    assign result             = mem_to_reg ? data_q : aluout_q;
    assign rf_we              = (state_q == WB) && reg_write;
    assign pc_next_d          = pc_src ? result : pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            flags_q     <= '0;
            retire_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            aluout_q    <= '0;
            data_q      <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                // FETCH: the request is normally raised on the WB edge; the
                // idle branch only runs once, straight after reset.
                FETCH: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        instr_q   <= mem_rdata[31:0];
                        pc_q      <= pc_q + WIDTH'(4);
                        mem_req_q <= 1'b0;
                        state_q   <= DECODE;
                    end
                end
                // DECODE: operand and immediate latch.
                DECODE: begin
                    a_q     <= rd1;
                    b_q     <= rd2;
                    imm_q   <= ext_imm(imm_src, instr_q[23:0]);
                    state_q <= EXEC;
                end
                // EXEC: ALU, flags, and the data request launched directly
                // so MEM starts with mem_req already valid.
                EXEC: begin
                    aluout_q <= alu_res;
                    flags_q  <= alu_flg;
                    if (needs_mem(mem_to_reg, mem_write)) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= mem_write;
                        mem_addr_q  <= alu_res;
                        mem_wdata_q <= b_q;
                        state_q     <= MEM;
                    end else begin
                        state_q <= WB;
                    end
                end
                // MEM: wait for the data handshake.
                MEM: begin
                    if (mem_ready) begin
                        if (mem_to_reg) begin
                            data_q <= mem_rdata;
                        end
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= WB;
                    end
                end
                // WB: register/PC update and the next fetch request.
                WB: begin
                    pc_q       <= pc_next_d;
                    retire_q   <= 1'b1;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_next_d;
                    state_q    <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign instr     = instr_q;
    assign alu_flags = flags_q;
    assign phase     = state_q;
    assign retire    = retire_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MC_DATAPATH_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire_q) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;
    localparam int W = 32;
`ifdef MC_DATAPATH_INSTRET_EN
    localparam bit IRET = 1'b1;
`else
    localparam bit IRET = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [1:0] reg_src, imm_src, alu_control;
    logic reg_write, alu_src, mem_to_reg, mem_write, pc_src;
    logic [31:0] instr;
    logic [3:0] alu_flags;
    logic [2:0] phase;
    logic retire, mem_req, mem_we, mem_ready;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] instret;

    int nerr = 0;
    int nchk = 0;

    // memory device: instruction supplied directly while fetching, data array otherwise
    logic [31:0] cur_instr;
    logic [31:0] dmem [0:255];
    logic [31:0] st_addr, st_data;
    int st_cnt = 0;

    // architectural reference model
    logic [31:0] mregs [0:14];
    logic [31:0] mdm [0:255];
    logic [31:0] m_pc;
    int m_ret;

    mc_datapath #(.WIDTH(W), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .reg_src(reg_src), .reg_write(reg_write),
        .imm_src(imm_src), .alu_src(alu_src), .alu_control(alu_control),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .pc_src(pc_src),
        .instr(instr), .alu_flags(alu_flags), .phase(phase), .retire(retire),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instret(instret)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (phase == 3'd0) ? cur_instr : dmem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we && !reset) begin
            dmem[mem_addr[9:2]] <= mem_wdata;
            st_addr <= mem_addr;
            st_data <= mem_wdata;
            st_cnt  <= st_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] imm);
        return {8'hE2, rn, rd, imm};
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] idx);
        return (idx == 4'd15) ? m_pc + 32'd8 : mregs[idx];
    endfunction

    function automatic logic [31:0] mext(input logic [31:0] iw, input logic [1:0] is);
        int off;
        case (is)
            2'b00: return {24'd0, iw[7:0]};
            2'b01: return {20'd0, iw[11:0]};
            2'b10: begin
                off = int'(iw[23:0]);
                if (iw[23]) off = off - (1 << 24);
                return 32'(off * 4);
            end
            default: return 32'd0;
        endcase
    endfunction

    // flags from plain integer arithmetic: C = unsigned overflow / no borrow,
    // V = exact signed result out of 32-bit range
    task automatic malu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f);
        longint s;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        r = 32'd0;
        case (op)
            2'b00: begin
                r = a + b;
                c = ((longint'(a) + longint'(b)) >= 64'sd4294967296);
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b01: begin
                r = a - b;
                c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endtask

    // Run one instruction from its FETCH to its retire pulse; starts and ends on a negedge.
    task automatic run(input logic [31:0] iw, input logic [1:0] rs, input logic rw,
                       input logic [1:0] is, input logic as, input logic [1:0] ac,
                       input logic m2r, input logic mw, input logic ps,
                       input int fw, input int mwt);
        logic [3:0] ra1, ra2, rd;
        logic [31:0] a, b, r, res;
        logic [3:0] fl;
        int n, fw_left, mw_left, st0, lat;
        bit done;
        ra1 = rs[0] ? 4'd15 : iw[19:16];
        ra2 = rs[1] ? iw[15:12] : iw[3:0];
        rd  = iw[15:12];
        a   = mread(ra1);
        b   = mread(ra2);
        malu(ac, a, as ? mext(iw, is) : b, r, fl);
        lat = ((m2r | mw) ? 5 + mwt : 4) + fw;

        cur_instr = iw; reg_src = rs; reg_write = rw; imm_src = is; alu_src = as;
        alu_control = ac; mem_to_reg = m2r; mem_write = mw; pc_src = ps;

        n = 0;
        while (!mem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_we", 32'(mem_we), 32'd0);
        st0 = st_cnt;
        fw_left = fw;
        mw_left = (m2r | mw) ? mwt : 0;
        n = 0;
        done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (phase == 3'd0) begin
                chk("fetch_req", 32'(mem_req), 32'd1);
                chk("fetch_addr", mem_addr, m_pc);
            end
            if (phase == 3'd3) begin
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_addr", mem_addr, r);
                chk("mem_we", 32'(mem_we), 32'(mw));
            end
            if (phase == 3'd0 && fw_left > 0) begin
                mem_ready = 1'b0;
                fw_left--;
            end else if (phase == 3'd3 && mw_left > 0) begin
                mem_ready = 1'b0;
                mw_left--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            n++;
            if (retire) done = 1;
        end
        chk("retire_seen", 32'(done), 32'd1);
        chk("latency", 32'(n), 32'(lat));
        chk("flags", 32'(alu_flags), 32'(fl));
        chk("phase_after", 32'(phase), 32'd0);
        chk("instret", instret, IRET ? 32'(m_ret) : 32'd0);
        chk("store_count", 32'(st_cnt - st0), 32'(mw));
        if (mw) begin
            chk("store_addr", st_addr, r);
            chk("store_data", st_data, b);
            mdm[r[9:2]] = b;
        end
        res = m2r ? mdm[r[9:2]] : r;
        if (rw && rd != 4'd15) mregs[rd] = res;
        m_pc = ps ? res : m_pc + 32'd4;
        m_ret++;
    endtask

    initial begin
        logic [31:0] iw;
        int kind;
        reset = 1'b1; cur_instr = 32'd0; mem_ready = 1'b1;
        reg_src = 2'b00; reg_write = 1'b0; imm_src = 2'b00; alu_src = 1'b0;
        alu_control = 2'b00; mem_to_reg = 1'b0; mem_write = 1'b0; pc_src = 1'b0;
        for (int i = 0; i < 256; i++) begin dmem[i] = 32'd0; mdm[i] = 32'd0; end
        for (int i = 0; i < 15; i++) mregs[i] = 32'd0;
        m_pc = 32'd0; m_ret = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_flags", 32'(alu_flags), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_instret", instret, 32'd0);

        // ADD R1,R15,#4 at PC 0 -> R1 = 0x0C
        run(mk(4'd15, 4'd1, 12'h004), 2'b01, 1, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
        // STR R1,[R0,#0x20]
        run(mk(4'd0, 4'd1, 12'h020), 2'b10, 0, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0);
        chk("str_r1_addr", st_addr, 32'h20);
        chk("str_r1_data", st_data, 32'h0C);
        // LDR R3,[R0,#0x20] with one data wait, then STR R3 to observe it
        run(mk(4'd0, 4'd3, 12'h020), 2'b00, 1, 2'b01, 1, 2'b00, 1, 0, 0, 0, 1);
        run(mk(4'd0, 4'd3, 12'h024), 2'b10, 0, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0);
        chk("ldr_r3_data", st_data, 32'h0C);
        // B -8 at PC 0x10 branches to itself
        run({8'hEA, 24'hFFFFFE}, 2'b01, 0, 2'b10, 1, 2'b00, 0, 0, 1, 0, 0);
        // ADD R1,R0,#5 with three fetch wait cycles
        run(mk(4'd0, 4'd1, 12'h005), 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 0, 3, 0);
        // SUB R2,R1,R1 -> Z and C
        run(mk(4'd1, 4'd2, 12'h001), 2'b00, 1, 2'b00, 0, 2'b01, 0, 0, 0, 0, 0);
        chk("sub_flags", 32'(alu_flags), 32'b0110);
        // write to R15 without pc_src is dropped
        run(mk(4'd0, 4'd15, 12'h040), 2'b00, 1, 2'b01, 1, 2'b00, 0, 0, 0, 0, 0);
        // build 0x7FFFFFFF in R4, then add 1 -> N and V
        run(mk(4'd0, 4'd4, 12'h001), 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
        repeat (31) run(mk(4'd4, 4'd4, 12'h004), 2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
        run(mk(4'd4, 4'd4, 12'h001), 2'b00, 1, 2'b00, 1, 2'b01, 0, 0, 0, 0, 0);
        run(mk(4'd4, 4'd5, 12'h001), 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
        chk("ovf_flags", 32'(alu_flags), 32'b1001);
        // imm_src 11 gives a zero immediate
        run(mk(4'd4, 4'd6, 12'hFFF), 2'b00, 1, 2'b11, 1, 2'b00, 0, 0, 0, 0, 0);

        // randomized mix of ALU, load and store
        for (int t = 0; t < 40; t++) begin
            iw = $urandom;
            iw[19:16] = 4'($urandom_range(0, 15));
            iw[15:12] = 4'($urandom_range(0, 14));
            kind = $urandom_range(0, 9);
            if (kind < 7)
                run(iw, 2'($urandom_range(0, 3)), 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 0, 0, 0, $urandom_range(0, 2), 0);
            else if (kind < 9)
                run(iw, {1'b1, 1'($urandom_range(0, 1))}, 0, 2'b01, 1, 2'b00, 0, 1, 0,
                    $urandom_range(0, 2), $urandom_range(0, 2));
            else
                run(iw, {1'b0, 1'($urandom_range(0, 1))}, 1, 2'b01, 1, 2'b00, 1, 0, 0,
                    $urandom_range(0, 2), $urandom_range(0, 2));
        end
        // expose every register through a store
        for (int i = 0; i < 15; i++)
            run(mk(4'd0, 4'(i), 12'h100), 2'b10, 0, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0);

        // reset while a store sits in MEM
        cur_instr = mk(4'd0, 4'd1, 12'h040);
        reg_src = 2'b10; reg_write = 1'b0; imm_src = 2'b01; alu_src = 1'b1;
        alu_control = 2'b00; mem_to_reg = 1'b0; mem_write = 1'b1; pc_src = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (phase == 3'd3) break;
            @(negedge clk);
        end
        chk("in_mem_phase", 32'(phase), 32'd3);
        mem_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_mem_req", 32'(mem_req), 32'd0);
        chk("mrst_phase", 32'(phase), 32'd0);
        chk("mrst_retire", 32'(retire), 32'd0);
        chk("mrst_flags", 32'(alu_flags), 32'd0);
        chk("mrst_instret", instret, 32'd0);
        for (int i = 0; i < 15; i++) mregs[i] = 32'd0;
        m_pc = 32'd0; m_ret = 0;
        mem_ready = 1'b1;
        // registers cleared; fetch restarts at RESET_PC
        run(mk(4'd0, 4'd1, 12'h030), 2'b10, 0, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0);
        chk("post_rst_r1", st_data, 32'd0);
        run(mk(4'd0, 4'd2, 12'h007), 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("instret_two", instret, IRET ? 32'(m_ret) : 32'd0);
        chk("stalled_fetch_addr", mem_addr, m_pc);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
